// File: rtl/rca_pkg.sv
// Shared constants for the pipelined ripple-carry adder: default geometry and op encoding.
package rca_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SEG_W_DEF = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/rca_segment.sv
// Purely combinational SEG_W-bit ripple chain of full adders; one instance per pipeline stage.
module rca_segment #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             c_i,
  output logic [SEG_W-1:0] s_o,
  output logic             c_o
);

  logic [SEG_W:0] c_s;

  // Ripple the carry bit by bit through the segment.
  always_comb begin
    c_s    = '0;
    s_o    = '0;
    c_s[0] = c_i;
    for (int i = 0; i < SEG_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c_s[SEG_W];
  end

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry add/subtract: one SEG_W-bit segment per stage, carry registered between stages.
// Defining PIPELINED_RCA_OVF_EN adds the registered signed-overflow output Ovf.
module pipelined_rca_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef PIPELINED_RCA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NUM_SEG = WIDTH / SEG_W;

  if (WIDTH % SEG_W != 0) begin : g_width_check
    $error("pipelined_rca_adder: WIDTH must be a multiple of SEG_W");
  end

  logic             sub_s;
  logic             advance_s;
  logic [WIDTH-1:0] b_inv_s;

  assign sub_s     = (op_e'(Sub) == OP_SUB);
  assign b_inv_s   = B ^ {WIDTH{sub_s}};
  // Global stall: the whole pipe moves only when the output slot is free or being drained.
  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    localparam int UP_W = WIDTH - (k + 1) * SEG_W;
    localparam int LO_W = (k + 1) * SEG_W;

    logic [SEG_W-1:0] a_seg_s;
    logic [SEG_W-1:0] b_seg_s;
    logic [SEG_W-1:0] seg_sum_s;
    logic             c_in_s;
    logic             seg_cout_s;
    logic             v_in_s;
    logic [LO_W-1:0]  sum_d;
    logic [LO_W-1:0]  sum_q;
    logic             vld_q;
    logic             carry_q;

    if (k == 0) begin : g_src
      assign a_seg_s = A[SEG_W-1:0];
      assign b_seg_s = b_inv_s[SEG_W-1:0];
      assign c_in_s  = Cin ^ sub_s;
      assign v_in_s  = in_valid;
      assign sum_d   = seg_sum_s;
    end else begin : g_src
      assign a_seg_s = g_stage[k-1].g_up.a_q[SEG_W-1:0];
      assign b_seg_s = g_stage[k-1].g_up.b_q[SEG_W-1:0];
      assign c_in_s  = g_stage[k-1].carry_q;
      assign v_in_s  = g_stage[k-1].vld_q;
      assign sum_d   = {seg_sum_s, g_stage[k-1].sum_q};
    end

    rca_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i (a_seg_s),
      .b_i (b_seg_s),
      .c_i (c_in_s),
      .s_o (seg_sum_s),
      .c_o (seg_cout_s)
    );

    // Stage valid, carry and the growing low part of the result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance_s) begin
        vld_q <= v_in_s;
        if (v_in_s) begin
          carry_q <= seg_cout_s;
          sum_q   <= sum_d;
        end
      end
    end

    // Operand segments not yet added ride along with the stage (input skew).
    if (UP_W > 0) begin : g_up
      logic [UP_W-1:0] a_d;
      logic [UP_W-1:0] b_d;
      logic [UP_W-1:0] a_q;
      logic [UP_W-1:0] b_q;

      if (k == 0) begin : g_fwd
        assign a_d = A[WIDTH-1:SEG_W];
        assign b_d = b_inv_s[WIDTH-1:SEG_W];
      end else begin : g_fwd
        assign a_d = g_stage[k-1].g_up.a_q[UP_W+SEG_W-1:SEG_W];
        assign b_d = g_stage[k-1].g_up.b_q[UP_W+SEG_W-1:SEG_W];
      end

      // Upper operand registers, loaded only for a valid transfer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance_s && v_in_s) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_SEG-1].vld_q;
  assign Sum       = g_stage[NUM_SEG-1].sum_q;
  assign Cout      = g_stage[NUM_SEG-1].carry_q;

`ifdef PIPELINED_RCA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Operands (after inversion) agree in sign but the result does not.
  assign ovf_d = (g_stage[NUM_SEG-1].a_seg_s[SEG_W-1] ~^ g_stage[NUM_SEG-1].b_seg_s[SEG_W-1])
               & (g_stage[NUM_SEG-1].seg_sum_s[SEG_W-1] ^ g_stage[NUM_SEG-1].a_seg_s[SEG_W-1]);

  // Overflow flag registered next to Cout, same stall behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance_s && g_stage[NUM_SEG-1].v_in_s) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule
